rx_burst: RTL and testbench
===========================

// Module: rx_burst
// PURPOSE
//  Receive-side counterpart of the GMSK transmit burst feeder. Takes hard-decision symbols
//  from the GMSK demodulator and searches for the training sequence (TSC) by sliding-window
//  Hamming compare. On sync it captures the rest of the burst, then holds one complete
//  148-bit normal burst for the deinterleaver/decoder via valid/ack.
// PARAMETERS
//  BURST_BITS   148          bits per normal burst (3 tail + 58 + 26 TSC + 58 + 3 tail)
//  SYNC_BITS    26           TSC length
//  SYNC_WORD    26'h0970897  TSC0; first-received bit is MSB
//  SYNC_END     87           burst bit count when the last TSC bit arrives
//  MAX_ERRORS   2            max Hamming distance accepted as sync
//  SEARCH_TIMEOUT 1250       strobes allowed in SEARCH (RX_BURST_TIMEOUT_EN only)
// PORTS
//  clock          in   1           system clock
//  reset_n        in   1           asynchronous, active-low reset
//  symbol_strobe  in   1           demodulator has a new symbol on symbol_in (1-cycle pulse)
//  symbol_in      in   1           hard-decision symbol
//  arm            in   1           pulse: begin searching for a burst
//  armed          out  1           1 while in SEARCH
//  burst_valid    out  1           burst_data holds a complete burst
//  burst_ack      in   1           consumer has taken burst_data
//  burst_data     out  BURST_BITS  [BURST_BITS-1] = first bit received, [0] = last
//  sync_errors    out  $clog2(SYNC_BITS+1)  Hamming distance at the accepted sync
//  timeout        out  1           1-cycle pulse: search abandoned (0 if macro absent)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE. All outputs 0. Shift register,
//  rx_count and remaining are 0.
//  States:
//  - IDLE: strobes ignored. arm -> SEARCH; clear shift register and rx_count.
//  - SEARCH (armed=1): each strobe shifts symbol_in into LSB; rx_count increments and
//    saturates at SYNC_END. Sync is judged on the post-shift window bits [SYNC_BITS-1:0].
//    Condition: popcount(window ^ SYNC_WORD) <= MAX_ERRORS AND rx_count+1 >= SYNC_END.
//    On sync: go to CAPTURE, latch sync_errors, set remaining = BURST_BITS-SYNC_END (61).
//    A match with rx_count+1 < SYNC_END is ignored (leading bits missing).
//  - CAPTURE: each strobe shifts and decrements remaining. The strobe that drives
//    remaining to 0 moves to HOLD. burst_valid rises on the next clock edge
//    (1-cycle latency from the 148th-bit strobe).
//  - HOLD: burst_valid=1; burst_data and sync_errors stable. Strobes dropped.
//    burst_ack -> IDLE, burst_valid 0 next cycle. arm without ack is ignored.
//    arm with ack in the same cycle -> SEARCH directly.
//  - arm in SEARCH or CAPTURE: restart SEARCH; clear counters and shift register.
//  - burst_data is undefined in meaning outside HOLD (it tracks the shift register).
//  - Arithmetic: popcount is unsigned, width $clog2(SYNC_BITS+1). Counters never wrap.
// CONFIGURATION
//  RX_BURST_TIMEOUT_EN defined:
//  - Counts strobes in SEARCH from arm. On reaching SEARCH_TIMEOUT without sync -> IDLE,
//    with a 1-cycle timeout pulse.
//  - Sync on the same strobe as timeout: sync wins, no pulse.
//  RX_BURST_TIMEOUT_EN undefined: SEARCH persists indefinitely; timeout tied 0; no counter.
// STRUCTURE
//  - Shared package gsm_burst_pkg: BURST_BITS, SYNC_BITS, SYNC_END, TSC0-TSC7 constants,
//    rx state encoding (IDLE/SEARCH/CAPTURE/HOLD).
//  - Sub-module rx_sync_correlator: combinational XOR and popcount of window vs SYNC_WORD.
//    Outputs distance and match (distance <= MAX_ERRORS).
//  - The FSM, shift register and counters live in rx_burst.
// TESTING
//  1 arm, then 148 strobes of a burst carrying exact TSC0 at bits 61..86 ->
//    burst_valid=1 one cycle after strobe 148; burst_data == sent; sync_errors=0.
//  2 Same burst, 2 TSC bits flipped -> captured, sync_errors=2.
//    3 bits flipped -> no capture, armed stays 1.
//  3 TSC0 pattern completed at strobe 40, then a valid burst -> early match ignored;
//    the later burst is captured correctly.
//  4 RX_BURST_TIMEOUT_EN, SEARCH_TIMEOUT=200, random data without TSC ->
//    timeout pulse after strobe 200; armed 0. Without macro: armed stays 1, timeout 0.
//  5 reset_n low mid-CAPTURE (strobe 100) -> all outputs 0 immediately.
//    Strobes ignored until next arm.
//  6 In HOLD: 10 extra strobes leave burst_data unchanged. burst_ack+arm same cycle ->
//    burst_valid 0 and armed 1 next cycle.

Source files
------------

// File: rtl/gsm_burst_pkg.sv
// Shared GSM burst constants: normal-burst geometry, training sequence codes
// TSC0..TSC7 (first-received bit is the MSB) and the receive FSM state encoding.
package gsm_burst_pkg;

    localparam int BURST_BITS = 148;
    localparam int SYNC_BITS  = 26;
    localparam int SYNC_END   = 87;
    localparam int ERR_W      = $clog2(SYNC_BITS + 1);
    localparam int CNT_W      = $clog2(SYNC_END + 1);
    localparam int REM_W      = $clog2(BURST_BITS - SYNC_END + 1);

    localparam logic [SYNC_BITS-1:0] TSC0 = 26'h0970897;
    localparam logic [SYNC_BITS-1:0] TSC1 = 26'h0B778B7;
    localparam logic [SYNC_BITS-1:0] TSC2 = 26'h10EE90E;
    localparam logic [SYNC_BITS-1:0] TSC3 = 26'h11ED11E;
    localparam logic [SYNC_BITS-1:0] TSC4 = 26'h06B906B;
    localparam logic [SYNC_BITS-1:0] TSC5 = 26'h13AC13A;
    localparam logic [SYNC_BITS-1:0] TSC6 = 26'h29F629F;
    localparam logic [SYNC_BITS-1:0] TSC7 = 26'h3BC4BBC;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_SEARCH  = 2'd1,
        RX_CAPTURE = 2'd2,
        RX_HOLD    = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_burst_if.sv
// Symbol input, control and burst handoff signals of rx_burst.
// slave: the receiver itself; master: the demodulator/consumer side driving it.
interface rx_burst_if
    import gsm_burst_pkg::*;
();
    logic                  symbol_strobe;
    logic                  symbol_in;
    logic                  arm;
    logic                  armed;
    logic                  burst_valid;
    logic                  burst_ack;
    logic [BURST_BITS-1:0] burst_data;
    logic [ERR_W-1:0]      sync_errors;
    logic                  timeout;

    modport slave (
        input  symbol_strobe, symbol_in, arm, burst_ack,
        output armed, burst_valid, burst_data, sync_errors, timeout
    );

    modport master (
        output symbol_strobe, symbol_in, arm, burst_ack,
        input  armed, burst_valid, burst_data, sync_errors, timeout
    );
endinterface

// File: rtl/rx_sync_correlator.sv
// Combinational Hamming compare of the current window against the sync word.
// distance = popcount(window ^ SYNC_WORD); match when distance <= MAX_ERRORS.
module rx_sync_correlator
    import gsm_burst_pkg::*;
#(
    parameter logic [SYNC_BITS-1:0] SYNC_WORD  = TSC0,
    parameter int                   MAX_ERRORS = 2
) (
    input  logic [SYNC_BITS-1:0] window_i,
    output logic [ERR_W-1:0]     distance_o,
    output logic                 match_o
);
    logic [SYNC_BITS-1:0] diff;

    // Population count of the bit differences
    always_comb begin
        diff       = window_i ^ SYNC_WORD;
        distance_o = '0;
        for (int i = 0; i < SYNC_BITS; i++) begin
            distance_o = distance_o + ERR_W'(diff[i]);
        end
        match_o = (distance_o <= ERR_W'(MAX_ERRORS));
    end
endmodule

// File: rtl/rx_burst.sv
// rx_burst: searches the hard-decision symbol stream for the training sequence,
// captures the rest of the normal burst after sync and holds it until acknowledged.
// Optional feature macro RX_BURST_TIMEOUT_EN: abandon SEARCH after SEARCH_TIMEOUT
// strobes with a one-cycle timeout pulse; when undefined SEARCH runs indefinitely.
module rx_burst
    import gsm_burst_pkg::*;
#(
    parameter logic [SYNC_BITS-1:0] SYNC_WORD      = TSC0,
    parameter int                   MAX_ERRORS     = 2,
    parameter int                   SEARCH_TIMEOUT = 1250
) (
    input  logic        clock,
    input  logic        reset_n,
    rx_burst_if.slave   bus
);
    localparam logic [CNT_W-1:0] SYNC_END_V = CNT_W'(SYNC_END);
    localparam logic [REM_W-1:0] REM_INIT   = REM_W'(BURST_BITS - SYNC_END);

    rx_state_t             state_q, state_d;
    logic [BURST_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      rx_count_q, rx_count_d;
    logic [REM_W-1:0]      remaining_q, remaining_d;
    logic [ERR_W-1:0]      sync_errors_q, sync_errors_d;
    logic                  valid_q, valid_d;
    logic                  armed_q, armed_d;

`ifdef RX_BURST_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  timeout_q, timeout_d;
`endif

    logic [BURST_BITS-1:0] shift_in;
    logic [ERR_W-1:0]      distance;
    logic                  match;
    logic                  sync_hit;
    logic                  clear_search;

    assign shift_in = {shreg_q[BURST_BITS-2:0], bus.symbol_in};

    rx_sync_correlator #(
        .SYNC_WORD  (SYNC_WORD),
        .MAX_ERRORS (MAX_ERRORS)
    ) u_corr (
        .window_i   (shift_in[SYNC_BITS-1:0]),
        .distance_o (distance),
        .match_o    (match)
    );

    // A match only counts once enough bits have arrived to hold the leading burst part
    assign sync_hit = match && ((rx_count_q + CNT_W'(1)) >= SYNC_END_V);

    // Next-state logic for the FSM, shift register and counters
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        rx_count_d    = rx_count_q;
        remaining_d   = remaining_q;
        sync_errors_d = sync_errors_q;
        valid_d       = valid_q;
        armed_d       = armed_q;
        clear_search  = 1'b0;
`ifdef RX_BURST_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                if (bus.arm) clear_search = 1'b1;
            end
            RX_SEARCH: begin
                if (bus.arm) begin
                    clear_search = 1'b1;
                end else if (bus.symbol_strobe) begin
                    shreg_d = shift_in;
                    if (rx_count_q != SYNC_END_V) rx_count_d = rx_count_q + CNT_W'(1);
                    if (sync_hit) begin
                        state_d       = RX_CAPTURE;
                        armed_d       = 1'b0;
                        sync_errors_d = distance;
                        remaining_d   = REM_INIT;
                    end
`ifdef RX_BURST_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        state_d   = RX_IDLE;
                        armed_d   = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
`endif
                end
            end
            RX_CAPTURE: begin
                if (bus.arm) begin
                    clear_search = 1'b1;
                end else if (bus.symbol_strobe) begin
                    shreg_d     = shift_in;
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) begin
                        state_d = RX_HOLD;
                        valid_d = 1'b1;
                    end
                end
            end
            RX_HOLD: begin
                if (bus.burst_ack) begin
                    valid_d = 1'b0;
                    if (bus.arm) clear_search = 1'b1;
                    else         state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (clear_search) begin
            state_d    = RX_SEARCH;
            armed_d    = 1'b1;
            shreg_d    = '0;
            rx_count_d = '0;
`ifdef RX_BURST_TIMEOUT_EN
            tmo_cnt_d  = '0;
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RX_IDLE;
            shreg_q       <= '0;
            rx_count_q    <= '0;
            remaining_q   <= '0;
            sync_errors_q <= '0;
            valid_q       <= 1'b0;
            armed_q       <= 1'b0;
`ifdef RX_BURST_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            rx_count_q    <= rx_count_d;
            remaining_q   <= remaining_d;
            sync_errors_q <= sync_errors_d;
            valid_q       <= valid_d;
            armed_q       <= armed_d;
`ifdef RX_BURST_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign bus.armed       = armed_q;
    assign bus.burst_valid = valid_q;
    assign bus.burst_data  = shreg_q;
    assign bus.sync_errors = sync_errors_q;
`ifdef RX_BURST_TIMEOUT_EN
    assign bus.timeout     = timeout_q;
`else
    assign bus.timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_rx_burst.sv
// Directed bench for rx_burst: sync/capture, error tolerance, early-match rejection,
// hold behaviour, search timeout (with or without RX_BURST_TIMEOUT_EN) and async reset.
module tb_rx_burst;
    import gsm_burst_pkg::*;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    rx_burst_if bus();

    rx_burst #(
        .SEARCH_TIMEOUT (200)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bursts: 3 tail + 58 data + TSC0 (sent bits 61..86) + 58 data + 3 tail
    localparam logic [57:0]  DATA_A = 58'h1234_5678_9AB_CDEF;
    localparam logic [57:0]  DATA_B = 58'h3C0F_F00F_A5A_55A5;
    localparam logic [147:0] B_EXACT = {3'b000, DATA_A, TSC0, DATA_B, 3'b000};
    localparam logic [147:0] B_ERR2  = B_EXACT ^ ((148'd1 << 70) | (148'd1 << 75));
    localparam logic [147:0] B_ERR3  = B_EXACT ^ ((148'd1 << 64) | (148'd1 << 70) | (148'd1 << 80));
    localparam logic [147:0] PRE40   = {14'd0, TSC0, 108'd0};

    task automatic chk(input string tag, input logic [147:0] got, input logic [147:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.symbol_strobe = 1'b1;
        bus.symbol_in     = b;
        @(posedge clock);
        #1;
        bus.symbol_strobe = 1'b0;
        bus.symbol_in     = 1'b0;
    endtask

    // Send the first n bits of v, MSB first
    task automatic send_bits(input logic [147:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[147-i]);
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        @(posedge clock);
        #1;
        bus.arm = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.burst_ack = 1'b1;
        @(posedge clock);
        #1;
        bus.burst_ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n           = 1'b0;
        bus.symbol_strobe = 1'b0;
        bus.symbol_in     = 1'b0;
        bus.arm           = 1'b0;
        bus.burst_ack     = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_armed", 148'(bus.armed), 148'd0);
        chk("rst_valid", 148'(bus.burst_valid), 148'd0);
        chk("rst_data", bus.burst_data, 148'd0);
        chk("rst_errs", 148'(bus.sync_errors), 148'd0);
        chk("rst_tmo", 148'(bus.timeout), 148'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Strobes in IDLE are ignored
        send_bits(B_EXACT, 10);
        chk("idle_data", bus.burst_data, 148'd0);

        // 1: exact TSC0 burst
        pulse_arm();
        chk("t1_armed", 148'(bus.armed), 148'd1);
        send_bits(B_EXACT, 147);
        chk("t1_valid_147", 148'(bus.burst_valid), 148'd0);
        send_bit(B_EXACT[0]);
        chk("t1_valid", 148'(bus.burst_valid), 148'd1);
        chk("t1_data", bus.burst_data, B_EXACT);
        chk("t1_errs", 148'(bus.sync_errors), 148'd0);
        chk("t1_armed_hold", 148'(bus.armed), 148'd0);

        // 6: strobes in HOLD dropped; ack+arm goes straight to SEARCH
        send_bits(~B_EXACT, 10);
        chk("t6_data", bus.burst_data, B_EXACT);
        chk("t6_valid", 148'(bus.burst_valid), 148'd1);
        pulse_arm();
        chk("t6_arm_no_ack", 148'(bus.burst_valid), 148'd1);
        bus.arm       = 1'b1;
        bus.burst_ack = 1'b1;
        @(posedge clock);
        #1;
        bus.arm       = 1'b0;
        bus.burst_ack = 1'b0;
        chk("t6_valid_ack", 148'(bus.burst_valid), 148'd0);
        chk("t6_armed_ack", 148'(bus.armed), 148'd1);

        // 2a: two TSC bits flipped still syncs
        send_bits(B_ERR2, 148);
        chk("t2_valid", 148'(bus.burst_valid), 148'd1);
        chk("t2_data", bus.burst_data, B_ERR2);
        chk("t2_errs", 148'(bus.sync_errors), 148'd2);
        pulse_ack();
        chk("t2_ack_valid", 148'(bus.burst_valid), 148'd0);
        chk("t2_ack_armed", 148'(bus.armed), 148'd0);

        // 2b: three TSC bits flipped does not sync
        pulse_arm();
        send_bits(B_ERR3, 148);
        chk("t2_3err_valid", 148'(bus.burst_valid), 148'd0);
        chk("t2_3err_armed", 148'(bus.armed), 148'd1);

        // 3: TSC completed at strobe 40 is ignored, following burst captured
        pulse_arm();
        send_bits(PRE40, 40);
        chk("t3_early_armed", 148'(bus.armed), 148'd1);
        chk("t3_early_valid", 148'(bus.burst_valid), 148'd0);
        send_bits(B_EXACT, 148);
        chk("t3_valid", 148'(bus.burst_valid), 148'd1);
        chk("t3_data", bus.burst_data, B_EXACT);
        chk("t3_errs", 148'(bus.sync_errors), 148'd0);
        pulse_ack();

        // 4: search timeout after 200 strobes of all-zero data
        pulse_arm();
        send_bits(148'd0, 148);
        send_bits(148'd0, 51);
        chk("t4_tmo_199", 148'(bus.timeout), 148'd0);
        chk("t4_armed_199", 148'(bus.armed), 148'd1);
        send_bit(1'b0);
`ifdef RX_BURST_TIMEOUT_EN
        chk("t4_tmo", 148'(bus.timeout), 148'd1);
        chk("t4_armed", 148'(bus.armed), 148'd0);
        @(posedge clock);
        #1;
        chk("t4_tmo_pulse", 148'(bus.timeout), 148'd0);
`else
        chk("t4_tmo", 148'(bus.timeout), 148'd0);
        chk("t4_armed", 148'(bus.armed), 148'd1);
`endif

        // 5: async reset mid-CAPTURE
        pulse_arm();
        send_bits(B_EXACT, 100);
        chk("t5_capture_armed", 148'(bus.armed), 148'd0);
        chk("t5_capture_valid", 148'(bus.burst_valid), 148'd0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_armed", 148'(bus.armed), 148'd0);
        chk("t5_rst_valid", 148'(bus.burst_valid), 148'd0);
        chk("t5_rst_data", bus.burst_data, 148'd0);
        chk("t5_rst_errs", 148'(bus.sync_errors), 148'd0);
        chk("t5_rst_tmo", 148'(bus.timeout), 148'd0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send_bits(B_EXACT, 148);
        chk("t5_post_valid", 148'(bus.burst_valid), 148'd0);
        chk("t5_post_armed", 148'(bus.armed), 148'd0);
        chk("t5_post_data", bus.burst_data, 148'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
